pulse_timer: RTL

PULSE_TIMER -- requirements
Module: pulse_timer

---
 rtl/pulse_timer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pulse_timer.sv
// pulse_timer: measures HIGH and LOW phase durations of a serial data line
// from one-cycle edge strobes. A saturating tick counter runs inside each
// phase and is captured on the edge that ends the phase. A long LOW phase
// is reported as a line reset, and out-of-order edges are reported as errors.
module pulse_timer #(
  parameter int WIDTH        = 10,
  parameter int RESET_THRESH = 512
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_count_enable,
  input  logic             i_rise,
  input  logic             i_fall,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_high_time,
  output logic             o_high_valid,
  output logic [WIDTH-1:0] o_low_time,
  output logic             o_bit_valid,
  output logic             o_reset_detect,
  output logic             o_sat,
  output logic             o_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] THRESH  = WIDTH'(RESET_THRESH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic [WIDTH-1:0] low_time_q, low_time_d;
  logic             high_valid_q, high_valid_d;
  logic             bit_valid_q, bit_valid_d;
  logic             reset_detect_q, reset_detect_d;
  logic             error_q, error_d;
  logic             sat_q, sat_d;

  // Saturating increment used whenever a phase runs without an edge.
  logic [WIDTH-1:0] count_inc;
  assign count_inc = (i_count_enable && (count_q != CNT_MAX)) ? count_q + WIDTH'(1) : count_q;

  // Next-state, counter and capture decisions for the current cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d        = state_q;
    count_d        = count_q;
    high_time_d    = high_time_q;
    low_time_d     = low_time_q;
    high_valid_d   = 1'b0;
    bit_valid_d    = 1'b0;
    reset_detect_d = 1'b0;
    error_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Counter held at zero; a rise (even with a fall) starts a HIGH phase.
        count_d = '0;
        if (i_rise) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (i_rise || i_fall) count_d = '0;
        if (i_rise && i_fall) begin
          error_d = 1'b1;
        end else if (i_fall) begin
          high_time_d  = count_q;
          high_valid_d = 1'b1;
          state_d      = S_LOW;
        end else if (i_rise) begin
          error_d = 1'b1;
        end else begin
          count_d = count_inc;
        end
      end
      S_LOW: begin
        if (i_rise || i_fall) count_d = '0;
        if (i_rise && i_fall) begin
          error_d = 1'b1;
        end else if (i_rise) begin
          low_time_d  = count_q;
          bit_valid_d = 1'b1;
          state_d     = S_HIGH;
        end else if (i_fall) begin
          error_d = 1'b1;
        end else if (count_q >= THRESH) begin
          // Line held low too long: report a line reset and wait for a rise.
          reset_detect_d = 1'b1;
          count_d        = '0;
          state_d        = S_IDLE;
        end else begin
          count_d = count_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    sat_d = (count_d == CNT_MAX);
  end

  // State, counter and registered outputs; reset overrides every input.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (i_reset) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      high_time_q    <= '0;
      low_time_q     <= '0;
      high_valid_q   <= 1'b0;
      bit_valid_q    <= 1'b0;
      reset_detect_q <= 1'b0;
      error_q        <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      high_time_q    <= high_time_d;
      low_time_q     <= low_time_d;
      high_valid_q   <= high_valid_d;
      bit_valid_q    <= bit_valid_d;
      reset_detect_q <= reset_detect_d;
      error_q        <= error_d;
      sat_q          <= sat_d;
    end
  end

  assign o_count        = count_q;
  assign o_high_time    = high_time_q;
  assign o_high_valid   = high_valid_q;
  assign o_low_time     = low_time_q;
  assign o_bit_valid    = bit_valid_q;
  assign o_reset_detect = reset_detect_q;
  assign o_sat          = sat_q;
  assign o_error        = error_q;

endmodule
